tree_out_arbiter: RTL and testbench

- Clocked round-robin arbiter for one output link of a tree-NoC router node.
- Shares the link among the node's input controllers: parent, child1 and child2 for N=3.
- Grants one requester per accepted packet and latches the winning packet in a one-entry output register with a valid/ready handshake.
- Sits between the per-port routing controllers and the outgoing link.

---
 rtl/tree_out_arbiter.sv | 117 +++++++++++
 tb/tb_tree_out_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tree_out_arbiter.sv
// Round-robin output-link arbiter with a one-entry valid/ready output register.
// Optional starvation override: define TREE_ARB_STARVE_EN.
module tree_out_arbiter #(
    parameter int WIDTH_packet = 14,
`ifdef TREE_ARB_STARVE_EN
    parameter int STARVE_LIMIT = 15,
`endif
    parameter int NUM_REQ = 3,
    localparam int SRC_W = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              in_valid,
    input  logic [NUM_REQ*WIDTH_packet-1:0] in_packet,
    output logic [NUM_REQ-1:0]              in_ready,
`ifdef TREE_ARB_STARVE_EN
    output logic [NUM_REQ-1:0]              starve_flag,
`endif
    output logic                            out_valid,
    output logic [WIDTH_packet-1:0]         out_packet,
    output logic [SRC_W-1:0]                out_src,
    input  logic                            out_ready
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   win;
    logic [SRC_W:0]     sum;
    logic               any;
    logic               can_load;
    logic               accept;

    assign can_load = (state_q == EMPTY) || out_ready;
    assign out_valid = (state_q == FULL);

    // Scan downward so the candidate closest to rr_ptr is assigned last and wins.
    always_comb begin
        win = '0;
        any = 1'b0;
        sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (sum >= (SRC_W+1)'(NUM_REQ))
                sum = sum - (SRC_W+1)'(NUM_REQ);
            if (in_valid[sum[SRC_W-1:0]]) begin
                win = sum[SRC_W-1:0];
                any = 1'b1;
            end
        end
`ifdef TREE_ARB_STARVE_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (in_valid[i] && starve_flag[i])
                win = SRC_W'(i);
        end
`endif
    end

    always_comb begin
        in_ready = '0;
        if (any && can_load && !reset)
            in_ready[win] = 1'b1;
    end

    assign accept = |(in_valid & in_ready);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (accept)         state_d = FULL;
                else if (out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_packet <= '0;
            out_src    <= '0;
            rr_ptr     <= '0;
        end else if (accept) begin
            out_packet <= in_packet[int'(win)*WIDTH_packet +: WIDTH_packet];
            out_src    <= win;
            rr_ptr     <= (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
    end

`ifdef TREE_ARB_STARVE_EN
    logic [3:0] wait_cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset || !in_valid[i] || in_ready[i])
                wait_cnt[i] <= '0;
            else if (wait_cnt[i] != 4'hF)
                wait_cnt[i] <= wait_cnt[i] + 4'd1;
        end
    end

    always_comb begin
        starve_flag = '0;
        for (int i = 0; i < NUM_REQ; i++)
            starve_flag[i] = int'(wait_cnt[i]) >= STARVE_LIMIT;
    end
`endif

endmodule

// File: tb/tb_tree_out_arbiter.sv
// Self-checking bench for tree_out_arbiter: vector table, hand sequences,
// and randomized traffic against a queue-free behavioural model.
module tb_tree_out_arbiter;

    localparam int W = 14;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_packet;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_packet;
    logic [1:0]     out_src;
    logic           out_ready;
`ifdef TREE_ARB_STARVE_EN
    logic [N-1:0]   starve_flag;
`endif

    int checks = 0;
    int errors = 0;

    tree_out_arbiter #(
        .WIDTH_packet (W),
`ifdef TREE_ARB_STARVE_EN
        .STARVE_LIMIT (3),
`endif
        .NUM_REQ      (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_packet  (in_packet),
        .in_ready   (in_ready),
`ifdef TREE_ARB_STARVE_EN
        .starve_flag(starve_flag),
`endif
        .out_valid  (out_valid),
        .out_packet (out_packet),
        .out_src    (out_src),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         rst;
        logic [2:0]   v;
        logic         ordy;
        logic [2:0]   rdy;
        logic         ov;
        logic [1:0]   src;
        logic [13:0]  pkt;
    } vec_t;

    localparam logic [13:0] P0 = 14'h0A01;
    localparam logic [13:0] P1 = 14'h1202;
    localparam logic [13:0] P2 = 14'h2403;

    vec_t tbl [19];

    // Behavioural reference state
    bit           m_valid;
    logic [W-1:0] m_pkt;
    int           m_src;
    int           m_ptr;

    function automatic int ref_winner(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        in_packet = {P2, P1, P0};

        tbl[0]  = '{1'b1, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0, 14'h0};
        tbl[1]  = '{1'b1, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0, 14'h0};
        tbl[2]  = '{1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, P0};
        tbl[3]  = '{1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, P1};
        tbl[4]  = '{1'b0, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, P2};
        tbl[5]  = '{1'b0, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, P0};
        tbl[6]  = '{1'b0, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, P1};
        tbl[7]  = '{1'b0, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, P2};
        tbl[8]  = '{1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 2'd2, P2};
        tbl[9]  = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd2, P2};
        tbl[10] = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd2, P2};
        tbl[11] = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd2, P2};
        tbl[12] = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'd2, P2};
        tbl[13] = '{1'b0, 3'b110, 1'b0, 3'b010, 1'b1, 2'd1, P1};
        tbl[14] = '{1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 2'd1, P1};
        tbl[15] = '{1'b0, 3'b111, 1'b0, 3'b000, 1'b1, 2'd1, P1};
        tbl[16] = '{1'b1, 3'b111, 1'b0, 3'b000, 1'b0, 2'd0, 14'h0};
        tbl[17] = '{1'b0, 3'b100, 1'b0, 3'b100, 1'b1, 2'd2, P2};
        tbl[18] = '{1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 2'd2, P2};

        #2;
        for (int i = 0; i < 19; i++) begin
            reset     = tbl[i].rst;
            in_valid  = tbl[i].v;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            tick();
            chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("tbl%0d out_src", i), 32'(out_src), 32'(tbl[i].src));
            chk($sformatf("tbl%0d out_packet", i), 32'(out_packet), 32'(tbl[i].pkt));
        end

        // Backpressure: requester 1 delivers 3FFF, then downstream stalls
        in_packet = {P2, 14'h3FFF, P0};
        in_valid  = 3'b010;
        out_ready = 1'b0;
        tick();
        chk("bp load src", 32'(out_src), 32'd1);
        chk("bp load pkt", 32'(out_packet), 32'h3FFF);
        in_valid = 3'b111;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("bp in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("bp hold valid", 32'(out_valid), 32'd1);
            chk("bp hold pkt", 32'(out_packet), 32'h3FFF);
        end
        in_valid  = 3'b000;
        out_ready = 1'b1;
        tick();
        chk("bp drain", 32'(out_valid), 32'd0);

`ifdef TREE_ARB_STARVE_EN
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 3'b001;
        tick();
        out_ready = 1'b0;
        in_valid  = 3'b100;
        for (int c = 0; c < 3; c++) tick();
        in_valid  = 3'b111;
        out_ready = 1'b1;
        #1;
        chk("starve flag", 32'(starve_flag), 32'b100);
        chk("starve grant", 32'(in_ready), 32'b100);
        tick();
        chk("starve src", 32'(out_src), 32'd2);
`else
        // Randomized traffic against the reference model
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        m_valid = 1'b0;
        m_pkt   = '0;
        m_src   = 0;
        m_ptr   = 0;
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] exp_rdy;
            int           w;
            bit           ld;
            in_valid  = N'($urandom);
            in_packet = (N*W)'({$urandom, $urandom});
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            w       = ref_winner(in_valid, m_ptr);
            ld      = (w >= 0) && (!m_valid || out_ready);
            exp_rdy = '0;
            if (ld) exp_rdy[w] = 1'b1;
            chk("rnd in_ready", 32'(in_ready), 32'(exp_rdy));
            if (ld) begin
                m_pkt   = in_packet[w*W +: W];
                m_src   = w;
                m_valid = 1'b1;
                m_ptr   = (w + 1) % N;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            tick();
            chk("rnd out_valid", 32'(out_valid), 32'(m_valid));
            chk("rnd out_src", 32'(out_src), 32'(m_src));
            chk("rnd out_packet", 32'(out_packet), 32'(m_pkt));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
